reg_pipe: RTL and testbench
===========================

# reg_pipe

Parametrised valid/ready register pipeline with bubble collapsing, synchronous flush and occupancy count. It generalises the fixed two-bit register-chain and clock-enable examples to WIDTH-bit data over DEPTH stages, and adds per-stage valid, backpressure and flush. It sits between any producer/consumer pair in the design that needs fixed latency, full throughput and stall tolerance.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  producer has data
- in_ready  out  1  pipe accepts data this cycle
- in_data  in  WIDTH  producer data
- out_valid  out  1  last stage holds valid data
- out_ready  in  1  consumer accepts data this cycle
- out_data  out  WIDTH  last-stage data
- count  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- State: per stage i (0..DEPTH-1), v[i] and d[i]. Stage DEPTH-1 drives out_valid/out_data.
- Ready chain (combinational): rdy[DEPTH] = out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush.
- Transfers: input when in_valid & in_ready; output when out_valid & out_ready.
- Stage update when rdy[i]: stage 0 loads v = in_valid & !flush, d = in_data; stage i>0 loads v[i-1], d[i-1].
- d[i] loads only when the incoming valid is 1; otherwise d[i] holds. This gives bubble collapse: an empty stage is filled even when downstream stalls.
- flush: all v cleared at the next edge. d holds. No input accepted in the flush cycle. An output transfer in the flush cycle (out_valid & out_ready) is complete.
- rst: all v ← 0, all d ← 0. rst overrides flush.
- count: registered, equal to the popcount of v after each edge; updated with v.
- Reset values: in_ready = 1 (if flush = 0), out_valid = 0, out_data = 0, count = 0.

## Timing
- Latency: a word accepted at edge N into an empty pipe appears on out_valid after edge N+DEPTH−1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput: one word per cycle with out_ready held high.
- Full (count = DEPTH) with out_ready = 0 gives in_ready = 0.
- Full with out_ready = 1 gives in_ready = 1: simultaneous push and pop, count stays DEPTH.
- The out_ready→in_ready path is combinational through DEPTH stages. This is accepted; no skid buffer.
- Words are never dropped, duplicated or reordered, except by flush or rst.
- rst or flush mid-stream: the first cycle after deassertion behaves as empty pipe.
- in_data is sampled only on an input transfer. in_valid may deassert freely; it is not required to hold.

## Structure
- Package reg_pipe_pkg: function cnt_w(depth) returning $clog2(depth+1); no typedefs beyond that.
- Sub-module reg_pipe_stage (WIDTH): holds v/d, has inputs ld, vin, din, clr, rst, and outputs v, d. reg_pipe instantiates DEPTH of them in a generate loop, plus the ready chain and count register.
- All sequential logic uses always_ff @(posedge clk) with nonblocking assignments. The ready chain uses always_comb.

## Test plan
- Reset: rst high 2 cycles, then low with in_valid = 0 → out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- Streaming: DEPTH = 4, out_ready = 1, push 0x01..0x10 back-to-back → out_data 0x01 first valid 4 cycles after the first push, then one word per cycle in order; count steady at 4.
- Backpressure/collapse: out_ready = 0, push 0xA0, idle 2 cycles, push 0xA1..0xA3 → count reaches 4, in_ready = 0. Release out_ready → 0xA0..0xA3 in order, no gaps once started.
- Full push+pop: full pipe, out_ready = 1 and in_valid = 1 for 5 cycles with 0xB0..0xB4 → in_ready = 1 throughout, count = 4, outputs in FIFO order.
- Flush: 3 words loaded, assert flush for 1 cycle with in_valid = 1 and out_ready = 1 → in_ready = 0 that cycle, head word transferred, count = 0 next cycle, flush-cycle input not seen at output.
- Reset mid-operation: rst asserted while full and while flush = 1 → count = 0, out_data = 0 next cycle. Next push appears after 4 cycles.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe valid/ready register pipeline.
package reg_pipe_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid bit plus data word.
// Latency: 1 cycle. Loads only when ld is high; data is kept when the incoming valid is low.
// clr drops the valid but keeps the data; rst clears both.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr) begin
      v_d = 1'b0;
    end else if (ld) begin
      v_d = vin;
      if (vin) d_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Latency: DEPTH cycles from in_valid to out_valid; full throughput with out_ready high.
// Backpressure: out_ready ripples combinationally to in_ready; empty stages fill during stalls.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]   rdy;
  logic             rdy_run;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // A stage can load when it is empty or its successor can load.
  always_comb begin
    rdy_run    = out_ready;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_run = !v[i] | rdy_run;
      rdy[i]  = rdy_run;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din_i;
    if (i == 0) begin : g_head
      assign vin[i] = in_valid & ~flush;
      assign din_i  = in_data;
    end else begin : g_body
      assign vin[i] = v[i-1];
      assign din_i  = d[i-1];
    end

    reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .ld  (rdy[i]),
      .vin (vin[i]),
      .din (din_i),
      .clr (flush),
      .v   (v[i]),
      .d   (d[i])
    );
  end

  // Count tracks the valids the stages will hold after this edge.
  always_comb begin
    count_d = '0;
    v_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_nxt[i] = flush ? 1'b0 : (rdy[i] ? vin[i] : v[i]);
      count_d  = count_d + CW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe with WIDTH=8, DEPTH=4.
module tb_reg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    ncmp++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_out_data: got %0h want 00", out_data); end
    ncmp++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
    ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    step();
  endtask

  task automatic test_stream();
    int popped, exp_cnt, cap;
    out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      cap     = (c < 20) ? c : 20;
      popped  = (cap > 4) ? cap - 4 : 0;
      exp_cnt = ((c < 16) ? c : 16) - popped;
      ncmp++; if (out_valid !== (c >= 4 && c <= 19)) begin nerr++; $display("FAIL stream_valid c=%0d: got %0b want %0b", c, out_valid, (c >= 4 && c <= 19)); end
      if (c >= 4 && c <= 19) begin
        ncmp++; if (out_data !== 8'(c - 3)) begin nerr++; $display("FAIL stream_data c=%0d: got %0h want %0h", c, out_data, 8'(c - 3)); end
      end
      ncmp++; if (count !== 3'(exp_cnt)) begin nerr++; $display("FAIL stream_count c=%0d: got %0d want %0d", c, count, exp_cnt); end
      ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stream_in_ready c=%0d: got %0b want 1", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic       vld_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] dat_tab [6] = '{8'hA0, 8'h55, 8'h55, 8'hA1, 8'hA2, 8'hA3};
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = vld_tab[c];
      in_data  = dat_tab[c];
      #1;
      ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_in_ready_fill c=%0d: got %0b want 1", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    ncmp++; if (count !== 3'd4) begin nerr++; $display("FAIL bp_count_full: got %0d want 4", count); end
    ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); end
    ncmp++; if (out_data !== 8'hA0) begin nerr++; $display("FAIL bp_head: got %0h want a0", out_data); end
    step();
    for (int j = 0; j < 4; j++) begin
      out_ready = 1'b1;
      #1;
      ncmp++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_drain_valid j=%0d: got %0b want 1", j, out_valid); end
      ncmp++; if (out_data !== 8'(8'hA0 + j)) begin nerr++; $display("FAIL bp_drain_data j=%0d: got %0h want %0h", j, out_data, 8'(8'hA0 + j)); end
      step();
    end
    #1;
    ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty_valid: got %0b want 0", out_valid); end
    ncmp++; if (count !== 3'd0) begin nerr++; $display("FAIL bp_empty_count: got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_out [9] = '{8'h90, 8'h91, 8'h92, 8'h93, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h90 + c);
      step();
    end
    in_valid = 1'b0;
    #1;
    ncmp++; if (count !== 3'd4) begin nerr++; $display("FAIL pp_count_full: got %0d want 4", count); end
    ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL pp_in_ready_stall: got %0b want 0", in_ready); end
    for (int k = 0; k < 9; k++) begin
      out_ready = 1'b1;
      in_valid  = (k < 5);
      in_data   = 8'(8'hB0 + k);
      #1;
      if (k < 5) begin
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL pp_in_ready k=%0d: got %0b want 1", k, in_ready); end
        ncmp++; if (count !== 3'd4) begin nerr++; $display("FAIL pp_count k=%0d: got %0d want 4", k, count); end
      end
      ncmp++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL pp_valid k=%0d: got %0b want 1", k, out_valid); end
      ncmp++; if (out_data !== exp_out[k]) begin nerr++; $display("FAIL pp_data k=%0d: got %0h want %0h", k, out_data, exp_out[k]); end
      step();
    end
    in_valid = 1'b0;
    #1;
    ncmp++; if (count !== 3'd0) begin nerr++; $display("FAIL pp_drained_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + c);
      step();
    end
    in_valid = 1'b0;
    step();
    #1;
    ncmp++; if (count !== 3'd3) begin nerr++; $display("FAIL fl_count_pre: got %0d want 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL fl_in_ready: got %0b want 0", in_ready); end
    ncmp++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fl_head_valid: got %0b want 1", out_valid); end
    ncmp++; if (out_data !== 8'hC0) begin nerr++; $display("FAIL fl_head_data: got %0h want c0", out_data); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    ncmp++; if (count !== 3'd0) begin nerr++; $display("FAIL fl_count_post: got %0d want 0", count); end
    ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL fl_in_ready_post: got %0b want 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      #1;
      ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fl_no_ghost c=%0d: got %0b want 0", c, out_valid); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hD0 + c);
      step();
    end
    #1;
    ncmp++; if (count !== 3'd4) begin nerr++; $display("FAIL rm_count_full: got %0d want 4", count); end
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    ncmp++; if (count !== 3'd0) begin nerr++; $display("FAIL rm_count: got %0d want 0", count); end
    ncmp++; if (out_data !== 8'h00) begin nerr++; $display("FAIL rm_out_data: got %0h want 00", out_data); end
    ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_out_valid: got %0b want 0", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c == 0);
      in_data  = 8'hE5;
      #1;
      ncmp++; if (out_valid !== (c == 4)) begin nerr++; $display("FAIL rm_latency c=%0d: got %0b want %0b", c, out_valid, (c == 4)); end
      if (c == 4) begin
        ncmp++; if (out_data !== 8'hE5) begin nerr++; $display("FAIL rm_data: got %0h want e5", out_data); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
